imm_enc: RTL and testbench

Immediate encoder for the RISC-V core's instruction path. It takes a 32-bit immediate value and an instruction type, then inserts the immediate into the type-specific bit fields of an instruction word, keeping every non-immediate field (opcode, rd, rs1, rs2, funct) from the input word. It flags immediates that cannot be represented in that field format. It sits between the test/boot instruction generator and instruction memory, and its output round-trips exactly through the core's immediate generator. It is a two-stage valid/ready pipeline with a saturating error counter.

---
 rtl/imm_enc_if.sv | 22 ++
 rtl/imm_enc.sv | 128 ++++++++++++
 tb/tb_imm_enc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_enc_if.sv
// Handshake and data bundle for the immediate encoder: input word side and encoded output side.
interface imm_enc_if;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  sel_i;
    logic [31:0] imm_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic        err_o;

    modport slave (
        input  valid_i, sel_i, imm_i, instr_i, ready_i,
        output ready_o, valid_o, instr_o, err_o
    );

    modport master (
        output valid_i, sel_i, imm_i, instr_i, ready_i,
        input  ready_o, valid_o, instr_o, err_o
    );
endinterface

// File: rtl/imm_enc.sv
// Inserts an immediate into the type-specific fields of an instruction word and flags
// unrepresentable values; two-stage valid/ready pipeline with a saturating error counter.
module imm_enc #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_enc_if.slave             bus,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [2:0] {
        SEL_DEFAULT = 3'd0,
        SEL_REGIMM  = 3'd1,
        SEL_LOAD    = 3'd2,
        SEL_STORE   = 3'd3,
        SEL_BRANCH  = 3'd4,
        SEL_JALR    = 3'd5,
        SEL_JAL     = 3'd6,
        SEL_UPPER   = 3'd7
    } sel_e;

    sel_e        sel;
    logic [31:0] imm;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        hi11_ok, hi12_ok, hi20_ok;

    logic        s1_valid, s1_err;
    logic [31:0] s1_word;
    logic        s2_valid, s2_err;
    logic [31:0] s2_word;
    logic        s2_adv, s1_adv, in_hs, out_err_hs;

    assign sel = sel_e'(bus.sel_i);
    assign imm = bus.imm_i;

    // Sign-extension checks: the dropped high bits must all copy the field's top bit.
    assign hi11_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign hi12_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign hi20_ok = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = bus.instr_i;
        enc_err  = 1'b0;
        case (sel)
            SEL_REGIMM, SEL_LOAD, SEL_JALR: begin
                enc_word[31:20] = imm[11:0];
                enc_err         = !hi11_ok;
            end
            SEL_STORE: begin
                enc_word[31:25] = imm[11:5];
                enc_word[11:7]  = imm[4:0];
                enc_err         = !hi11_ok;
            end
            SEL_BRANCH: begin
                enc_word[31]    = imm[12];
                enc_word[30:25] = imm[10:5];
                enc_word[11:8]  = imm[4:1];
                enc_word[7]     = imm[11];
                enc_err         = !hi12_ok || imm[0];
            end
            SEL_JAL: begin
                enc_word[31]    = imm[20];
                enc_word[30:21] = imm[10:1];
                enc_word[20]    = imm[11];
                enc_word[19:12] = imm[19:12];
                enc_err         = !hi20_ok || imm[0];
            end
            SEL_UPPER: begin
                enc_word[31:12] = imm[19:0];
                enc_err         = |imm[31:20];
            end
            default: ;
        endcase
    end

    assign s2_adv      = !s2_valid || bus.ready_i;
    assign s1_adv      = s1_valid && s2_adv;
    assign bus.ready_o = !s1_valid || s2_adv;
    assign in_hs       = bus.valid_i && bus.ready_o;
    assign out_err_hs  = s2_valid && bus.ready_i && s2_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_err   <= 1'b0;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_word  <= enc_word;
            s1_err   <= enc_err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output data only changes when stage 1 advances, which keeps it stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_word  <= s1_word;
            s2_err   <= s1_err;
        end else if (bus.ready_i) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (out_err_hs && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    assign bus.valid_o = s2_valid;
    assign bus.instr_o = s2_word;
    assign bus.err_o   = s2_err;

endmodule

// File: tb/tb_imm_enc.sv
// Directed-vector bench for imm_enc: encoding, error flags, latency, backpressure,
// counter saturation/clear and asynchronous reset, on an 8-bit and a 2-bit counter instance.
module tb_imm_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr8, clr2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    imm_enc_if bus8();
    imm_enc_if bus2();

    imm_enc #(.ERR_CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave), .err_clr_i(clr8), .err_cnt_o(cnt8)
    );
    imm_enc #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .err_clr_i(clr2), .err_cnt_o(cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive8(input logic v, input logic [2:0] s, input logic [31:0] im, input logic [31:0] ins);
        bus8.valid_i = v;
        bus8.sel_i   = s;
        bus8.imm_i   = im;
        bus8.instr_i = ins;
    endtask

    task automatic drive2(input logic v, input logic [2:0] s, input logic [31:0] im, input logic [31:0] ins);
        bus2.valid_i = v;
        bus2.sel_i   = s;
        bus2.imm_i   = im;
        bus2.instr_i = ins;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (bus8.valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus8.valid_o); end
        n_cmp++; if (bus8.instr_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 00000000", bus8.instr_o); end
        n_cmp++; if (bus8.err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus8.err_o); end
        n_cmp++; if (cnt8 !== 8'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 00", cnt8); end
        n_cmp++; if (bus8.ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready_in_reset: got %b want 1", bus8.ready_o); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        n_cmp++; if (bus8.ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", bus8.ready_o); end
    endtask

    task automatic test_single(input string name, input logic [2:0] s, input logic [31:0] im,
                               input logic [31:0] ins, input logic [31:0] exp_w, input logic exp_e);
        bus8.ready_i = 1'b1;
        drive8(1'b1, s, im, ins);
        tick();
        drive8(1'b0, 3'd0, 32'h0, 32'h0);
        settle();
        n_cmp++; if (bus8.valid_o !== 1'b0) begin n_bad++; $display("FAIL %s_latency: valid_o %b one edge after accept, want 0", name, bus8.valid_o); end
        tick();
        n_cmp++; if (bus8.valid_o !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %b want 1", name, bus8.valid_o); end
        n_cmp++; if (bus8.instr_o !== exp_w) begin n_bad++; $display("FAIL %s_instr: got %h want %h", name, bus8.instr_o, exp_w); end
        n_cmp++; if (bus8.err_o !== exp_e) begin n_bad++; $display("FAIL %s_err: got %b want %b", name, bus8.err_o, exp_e); end
        tick();
    endtask

    task automatic test_regimm;
        test_single("regimm", 3'd1, 32'hFFFF_F800, 32'h0000_0093, 32'h8000_0093, 1'b0);
    endtask

    task automatic test_branch;
        test_single("branch", 3'd4, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    endtask

    task automatic test_errors;
        logic [2:0]  sels [3] = '{3'd4, 3'd6, 3'd7};
        logic [31:0] imms [3] = '{32'h0000_1000, 32'h0000_0003, 32'h0010_0000};
        logic [31:0] inss [3] = '{32'h0000_0063, 32'h0000_006F, 32'h0000_0037};
        logic [31:0] exps [3] = '{32'h8000_0063, 32'h0020_006F, 32'h0000_0037};
        bus8.ready_i = 1'b1;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        n_cmp++; if (cnt8 !== 8'd0) begin n_bad++; $display("FAIL err_clear: got %0d want 0", cnt8); end
        for (int k = 0; k < 3; k++) begin
            drive8(1'b1, sels[k], imms[k], inss[k]);
            tick();
            drive8(1'b0, 3'd0, 32'h0, 32'h0);
            tick();
            n_cmp++; if (bus8.err_o !== 1'b1) begin n_bad++; $display("FAIL err_flag%0d: got %b want 1", k, bus8.err_o); end
            n_cmp++; if (bus8.instr_o !== exps[k]) begin n_bad++; $display("FAIL err_instr%0d: got %h want %h", k, bus8.instr_o, exps[k]); end
            tick();
            n_cmp++; if (cnt8 !== 8'(k + 1)) begin n_bad++; $display("FAIL err_cnt%0d: got %0d want %0d", k, cnt8, k + 1); end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  sels [6] = '{3'd3, 3'd5, 3'd0, 3'd6, 3'd7, 3'd2};
        logic [31:0] imms [6] = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0001_2345, 32'hFFFF_FFFF};
        logic [31:0] inss [6] = '{32'h0000_2023, 32'h0000_8067, 32'h1234_5678, 32'h0000_006F, 32'hABCD_E0B7, 32'h0000_2003};
        logic [31:0] exps [6] = '{32'h7E00_2FA3, 32'h8000_8067, 32'h1234_5678, 32'h800F_F06F, 32'h1234_50B7, 32'hFFF0_2003};
        logic        errs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus8.ready_i = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            if (t < 6) drive8(1'b1, sels[t], imms[t], inss[t]);
            else       drive8(1'b0, 3'd0, 32'h0, 32'h0);
            settle();
            n_cmp++; if (bus8.ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", t, bus8.ready_o); end
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus8.valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d: got %b want 1", t - 1, bus8.valid_o); end
                n_cmp++; if (bus8.instr_o !== exps[t-1]) begin n_bad++; $display("FAIL b2b_instr%0d: got %h want %h", t - 1, bus8.instr_o, exps[t-1]); end
                n_cmp++; if (bus8.err_o !== errs[t-1]) begin n_bad++; $display("FAIL b2b_err%0d: got %b want %b", t - 1, bus8.err_o, errs[t-1]); end
            end
        end
        tick();
        n_cmp++; if (bus8.valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: valid_o %b want 0", bus8.valid_o); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w [4] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        int   idx = 0;
        logic acc;
        bus8.ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive8(1'b1, 3'd0, 32'h0, w[idx]);
            settle();
            acc = bus8.ready_o;
            tick();
            if (acc) idx++;
            if (c >= 1) begin
                n_cmp++; if (bus8.valid_o !== 1'b1 || bus8.instr_o !== w[0]) begin
                    n_bad++; $display("FAIL bp_hold%0d: valid %b instr %h want 1 %h", c, bus8.valid_o, bus8.instr_o, w[0]);
                end
            end
        end
        n_cmp++; if (idx !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        settle();
        n_cmp++; if (bus8.ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", bus8.ready_o); end
        bus8.ready_i = 1'b1;
        settle();
        n_cmp++; if (bus8.ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_same_cycle: got %b want 1", bus8.ready_o); end
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                n_cmp++; if (bus8.valid_o !== 1'b1 || bus8.instr_o !== w[c]) begin
                    n_bad++; $display("FAIL bp_out%0d: valid %b instr %h want 1 %h", c, bus8.valid_o, bus8.instr_o, w[c]);
                end
            end else begin
                n_cmp++; if (bus8.valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_empty: valid %b want 0", bus8.valid_o); end
            end
            acc = bus8.ready_o && bus8.valid_i;
            tick();
            if (acc) idx++;
            if (idx < 4) drive8(1'b1, 3'd0, 32'h0, w[idx]);
            else         drive8(1'b0, 3'd0, 32'h0, 32'h0);
            settle();
        end
    endtask

    task automatic test_saturation;
        bus2.ready_i = 1'b1;
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        n_cmp++; if (cnt2 !== 2'd0) begin n_bad++; $display("FAIL sat_clear: got %0d want 0", cnt2); end
        for (int t = 0; t < 5; t++) begin
            drive2(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0037);
            tick();
        end
        drive2(1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        n_cmp++; if (cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt: got %0d want 3", cnt2); end
        drive2(1'b1, 3'd1, 32'h0000_1000, 32'h0000_0013);
        tick();
        drive2(1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        clr2 = 1'b1;
        settle();
        n_cmp++; if (bus2.valid_o !== 1'b1 || bus2.err_o !== 1'b1) begin
            n_bad++; $display("FAIL sat_clr_setup: valid %b err %b want 1 1", bus2.valid_o, bus2.err_o);
        end
        tick();
        clr2 = 1'b0;
        n_cmp++; if (cnt2 !== 2'd0) begin n_bad++; $display("FAIL sat_clr_priority: got %0d want 0", cnt2); end
    endtask

    task automatic test_async_reset;
        n_cmp++; if (cnt8 !== 8'd4) begin n_bad++; $display("FAIL ar_cnt_before: got %0d want 4", cnt8); end
        bus8.ready_i = 1'b0;
        drive8(1'b1, 3'd0, 32'h0, 32'hDEAD_BEEF);
        tick();
        drive8(1'b1, 3'd0, 32'h0, 32'hCAFE_F00D);
        tick();
        drive8(1'b0, 3'd0, 32'h0, 32'h0);
        settle();
        n_cmp++; if (bus8.valid_o !== 1'b1 || bus8.ready_o !== 1'b0) begin
            n_bad++; $display("FAIL ar_full: valid %b ready %b want 1 0", bus8.valid_o, bus8.ready_o);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus8.valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_valid_async: got %b want 0", bus8.valid_o); end
        n_cmp++; if (bus8.instr_o !== 32'h0) begin n_bad++; $display("FAIL ar_instr: got %h want 00000000", bus8.instr_o); end
        n_cmp++; if (bus8.ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_ready: got %b want 1", bus8.ready_o); end
        n_cmp++; if (cnt8 !== 8'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want 0", cnt8); end
        tick();
        tick();
        rst = 1'b1;
        bus8.ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (bus8.valid_o !== 1'b0 || bus8.ready_o !== 1'b1) begin
                n_bad++; $display("FAIL ar_post%0d: valid %b ready %b want 0 1", c, bus8.valid_o, bus8.ready_o);
            end
        end
    endtask

    initial begin
        clr8 = 1'b0;
        clr2 = 1'b0;
        drive8(1'b0, 3'd0, 32'h0, 32'h0);
        drive2(1'b0, 3'd0, 32'h0, 32'h0);
        bus8.ready_i = 1'b1;
        bus2.ready_i = 1'b1;
        test_reset();
        test_regimm();
        test_branch();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
